ucaspian_synapse: RTL and testbench
===================================

# ucaspian_synapse

Synapse dispatch stage of the uCaspian core, directly downstream of the axon. It accepts one synapse range (`syn_start`..`syn_end`, inclusive, 12-bit) per handshake from the axon. It walks that range through a 4096-entry synapse RAM and emits one (target neuron, signed weight) event per non-zero-weight synapse to the dendrite/neuron accumulation stage. It also owns synapse configuration and clearing, and reports step completion for time-step synchronisation.

## Interface
- No parameters. Synapse RAM is fixed at 4096 x 16: bits [15:8] hold the signed weight, bits [7:0] hold the target neuron.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new RAM reads are issued; all state holds.
- `clear_config` in 1: level request to zero the whole synapse RAM.
- `clear_done` out 1: registered; high while `clear_config` is high and the clear has completed.
- `config_addr` in 12: synapse index to configure.
- `config_value` in 8: configuration payload.
- `config_byte` in 3: configuration phase (1, 2 or 3).
- `config_enable` in 1: configuration strobe.
- `next_step` in 1: time-step boundary pulse.
- `step_done` out 1: registered; this stage is drained.
- `syn_start` in 12: first synapse of the range.
- `syn_end` in 12: last synapse of the range (inclusive).
- `syn_vld` in 1: range valid.
- `syn_rdy` out 1: ready to accept a range.
- `dend_addr` out 8: target neuron.
- `dend_weight` out 8: signed weight.
- `dend_vld` out 1: event valid.
- `dend_rdy` in 1: downstream accepts the event.

## Operation
- States: IDLE, RUN, CLEAR.
- `syn_rdy` = (state == IDLE) && !`clear_config` && `reset` deasserted. A range is accepted on a clock edge where both `syn_vld` and `syn_rdy` are high; the block latches `cur` = `syn_start` and `last` = `syn_end`, then moves to RUN.
- RUN issues reads in the following manner:
  - One read is issued per cycle at `cur`, provided `enable` is high and the skid register is empty.
  - After each read, `cur` increments modulo 4096. A range with `syn_end` < `syn_start` therefore wraps 4095 -> 0.
  - After issuing the read at `last`, the state returns to IDLE.
- Read data returns one cycle after issue. It loads the output register if that register is empty or being consumed this cycle; otherwise it loads the one-entry skid register. A skid entry moves to the output register with priority over new data.
- Synapses with weight == 0 are dropped: no event, no stall.
- Event handshake: `dend_addr`, `dend_weight` and `dend_vld` hold stable until `dend_vld && dend_rdy`.
- Configuration applies only when `config_enable` is high and `clear_config` is low:
  - byte 1 zeroes the staging word;
  - byte 2 sets weight = `config_value`;
  - byte 3 sets target = `config_value` and writes the staging word to `config_addr`.
- A configuration write to the address being read in the same cycle returns the old data.
- `clear_config` high takes any state to CLEAR:
  - Any in-progress range is aborted; `dend_vld` and the skid register are cleared.
  - Addresses 0..4095 are written with 0, one per cycle.
  - `clear_done` goes high the cycle after address 4095 is written and stays high until `clear_config` falls.
  - The state then returns to IDLE and the clear counter resets to 0.
- `step_done` <= (state == IDLE) && no read in flight && skid register empty && !`dend_vld` && !`syn_vld` && !`clear_config`.
- `next_step` has no effect on datapath state.

## Timing
- Reset-asserted values: `syn_rdy` 0, `dend_vld` 0, `dend_addr` 0, `dend_weight` 0, `step_done` 0, `clear_done` 0. State is IDLE, skid register empty, clear counter 0. RAM contents are not reset.
- Range of N synapses, accepted at edge E, with `dend_rdy` held high and all weights non-zero:
  - reads issue in cycles E+1 .. E+N;
  - `dend_vld` is high in cycles E+2 .. E+N+1, with one event per cycle;
  - `syn_rdy` is high again from cycle E+N+1.
- `dend_rdy` low stalls with no loss: at most one read in flight plus one skid entry.
- Reset asserted mid-range discards the range immediately (asynchronous).
- A clear takes 4096 cycles of writes, plus 1 cycle to `clear_done`.

## Test plan
- Program synapse 10 = {w=+5, t=3} and 11 = {w=-2, t=7}; send range 10..11 with `dend_rdy`=1 -> events (3,+5) at E+2 and (7,-2) at E+3; `syn_rdy` is high at E+3.
- Program synapses 4094, 4095 and 0 with non-zero weights; send range 4094..0 -> three events in address order 4094, 4095, 0.
- Range 20..23 with weight of synapse 21 = 0 -> three events only, with a one-cycle `dend_vld` gap in the slot for 21.
- Range 0..7 with `dend_rdy` toggled 1/0 every cycle -> all 8 events delivered exactly once, in order, with outputs stable while stalled.
- Assert `clear_config` mid-range -> `dend_vld` drops the next cycle; `clear_done` rises 4097 cycles after assertion; a subsequent range emits no events.
- After the last event is consumed and `syn_vld`=0 -> `step_done`=1 one cycle later; assert `reset` low -> all outputs 0 immediately.

Source files
------------

// File: rtl/ucaspian_synapse.sv
// Synapse dispatch: walks an inclusive synapse range through a 4096x16 RAM and
// emits (target, weight) events for non-zero weights; also handles config and clear.
module ucaspian_synapse (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_config,
  output logic        clear_done,
  input  logic [11:0] config_addr,
  input  logic [7:0]  config_value,
  input  logic [2:0]  config_byte,
  input  logic        config_enable,
  input  logic        next_step,
  output logic        step_done,
  input  logic [11:0] syn_start,
  input  logic [11:0] syn_end,
  input  logic        syn_vld,
  output logic        syn_rdy,
  output logic [7:0]  dend_addr,
  output logic [7:0]  dend_weight,
  output logic        dend_vld,
  input  logic        dend_rdy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_e;

  state_e      state_q, state_d;
  logic [11:0] cur_q, cur_d, last_q, last_d;
  logic        fin_q, fin_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] stage_q, stage_d;
  logic [15:0] out_q, out_d, skid_q, skid_d;
  logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic        rd_vld_q, rd_issue;
  logic        step_done_q, step_done_d, clear_done_q, clear_done_d;
  logic [15:0] mem_q [4096];
  logic [15:0] rdata_q;
  logic        mem_we;
  logic [11:0] mem_wa;
  logic [15:0] mem_wd;
  logic        out_free, ret_ok;
  logic        unused_next_step;

  assign unused_next_step = next_step;

  assign syn_rdy     = (state_q == S_IDLE) && !clear_config && reset;
  assign dend_addr   = out_q[7:0];
  assign dend_weight = out_q[15:8];
  assign dend_vld    = out_vld_q;
  assign step_done   = step_done_q;
  assign clear_done  = clear_done_q;

  assign out_free = !out_vld_q || dend_rdy;
  assign ret_ok   = rd_vld_q && (rdata_q[15:8] != 8'd0);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    fin_d      = fin_q;
    clr_cnt_d  = clr_cnt_q;
    stage_d    = stage_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    rd_issue   = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = config_addr;
    mem_wd     = {stage_q[15:8], config_value};

    // Skid drains first; a live skid entry implies no read is in flight.
    if (skid_vld_q) begin
      if (out_free) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (ret_ok) begin
      if (out_free) begin
        out_d     = rdata_q;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = rdata_q;
        skid_vld_d = 1'b1;
      end
    end else if (out_free) begin
      out_vld_d = 1'b0;
    end

    if (config_enable && !clear_config) begin
      case (config_byte)
        3'd1: stage_d = 16'd0;
        3'd2: stage_d[15:8] = config_value;
        3'd3: begin
          stage_d[7:0] = config_value;
          mem_we       = 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: if (syn_vld && syn_rdy) begin
        cur_d   = syn_start;
        last_d  = syn_end;
        fin_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: if (fin_q) begin
        state_d = S_IDLE;
        fin_d   = 1'b0;
      // Hold off if the returning word would have to land in the skid slot.
      end else if (enable && !skid_vld_q && !(rd_vld_q && out_vld_q && !dend_rdy)) begin
        rd_issue = 1'b1;
        cur_d    = cur_q + 12'd1;
        if (cur_q == last_q) fin_d = 1'b1;
      end
      S_CLEAR: if (!clear_config) begin
        state_d   = S_IDLE;
        clr_cnt_d = 13'd0;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_config) begin
      state_d    = S_CLEAR;
      rd_issue   = 1'b0;
      fin_d      = 1'b0;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      if (!clr_cnt_q[12]) begin
        mem_we    = 1'b1;
        mem_wa    = clr_cnt_q[11:0];
        mem_wd    = 16'd0;
        clr_cnt_d = clr_cnt_q + 13'd1;
      end
    end

    step_done_d  = (state_q == S_IDLE) && !rd_vld_q && !skid_vld_q && !out_vld_q &&
                   !syn_vld && !clear_config;
    clear_done_d = clear_config && clr_cnt_q[12];
  end

  // Read-before-write: a same-cycle write to the read address returns old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
    rdata_q <= mem_q[cur_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_q        <= 12'd0;
      last_q       <= 12'd0;
      fin_q        <= 1'b0;
      clr_cnt_q    <= 13'd0;
      stage_q      <= 16'd0;
      out_q        <= 16'd0;
      out_vld_q    <= 1'b0;
      skid_q       <= 16'd0;
      skid_vld_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
      step_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      fin_q        <= fin_d;
      clr_cnt_q    <= clr_cnt_d;
      stage_q      <= stage_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      skid_q       <= skid_d;
      skid_vld_q   <= skid_vld_d;
      rd_vld_q     <= rd_issue;
      step_done_q  <= step_done_d;
      clear_done_q <= clear_done_d;
    end
  end
endmodule

// File: tb/tb_ucaspian_synapse.sv
// Directed bench for ucaspian_synapse: config, ranges, wrap, zero-drop, stalls, clear, reset.
module tb_ucaspian_synapse;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        clear_config = 1'b0;
  logic        clear_done;
  logic [11:0] config_addr = '0;
  logic [7:0]  config_value = '0;
  logic [2:0]  config_byte = '0;
  logic        config_enable = 1'b0;
  logic        next_step = 1'b0;
  logic        step_done;
  logic [11:0] syn_start = '0;
  logic [11:0] syn_end = '0;
  logic        syn_vld = 1'b0;
  logic        syn_rdy;
  logic [7:0]  dend_addr;
  logic [7:0]  dend_weight;
  logic        dend_vld;
  logic        dend_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  ucaspian_synapse dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_config(clear_config),
    .clear_done(clear_done), .config_addr(config_addr), .config_value(config_value),
    .config_byte(config_byte), .config_enable(config_enable), .next_step(next_step),
    .step_done(step_done), .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld),
    .syn_rdy(syn_rdy), .dend_addr(dend_addr), .dend_weight(dend_weight),
    .dend_vld(dend_vld), .dend_rdy(dend_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [11:0] a, input logic [7:0] w, input logic [7:0] t);
    config_addr   = a;
    config_enable = 1'b1;
    config_byte   = 3'd1;
    tick();
    config_byte  = 3'd2;
    config_value = w;
    tick();
    config_byte  = 3'd3;
    config_value = t;
    tick();
    config_enable = 1'b0;
    config_byte   = 3'd0;
  endtask

  // Leaves time just after the accepting edge E.
  task automatic send_range(input logic [11:0] s, input logic [11:0] e);
    syn_start = s;
    syn_end   = e;
    syn_vld   = 1'b1;
    tick();
    syn_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nev;
    logic stall;
    logic [7:0] pa, pw;

    #12;
    chk("rst_syn_rdy", syn_rdy, 0);
    chk("rst_dend_vld", dend_vld, 0);
    chk("rst_dend_addr", dend_addr, 0);
    chk("rst_dend_weight", dend_weight, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_clear_done", clear_done, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_syn_rdy", syn_rdy, 1);
    tick();
    chk("idle_step_done", step_done, 1);

    // Basic two-synapse range
    cfg(12'd10, 8'd5, 8'd3);
    cfg(12'd11, 8'hFE, 8'd7);
    send_range(12'd10, 12'd11);
    tick();
    chk("t1_e1_vld", dend_vld, 0);
    chk("t1_e1_rdy", syn_rdy, 0);
    tick();
    chk("t1_e2_vld", dend_vld, 1);
    chk("t1_e2_addr", dend_addr, 8'd3);
    chk("t1_e2_wt", dend_weight, 8'd5);
    chk("t1_e2_rdy", syn_rdy, 0);
    tick();
    chk("t1_e3_vld", dend_vld, 1);
    chk("t1_e3_addr", dend_addr, 8'd7);
    chk("t1_e3_wt", dend_weight, 8'hFE);
    chk("t1_e3_rdy", syn_rdy, 1);
    tick();
    chk("t1_e4_vld", dend_vld, 0);
    chk("t1_e4_step", step_done, 0);
    tick();
    chk("t1_e5_step", step_done, 1);

    // Wrap 4094..0
    cfg(12'd4094, 8'd1, 8'h11);
    cfg(12'd4095, 8'd2, 8'h22);
    cfg(12'd0, 8'd3, 8'h33);
    send_range(12'd4094, 12'd0);
    tick();
    tick();
    chk("wr_a0", dend_addr, 8'h11);
    chk("wr_w0", dend_weight, 8'd1);
    tick();
    chk("wr_a1", dend_addr, 8'h22);
    chk("wr_w1", dend_weight, 8'd2);
    chk("wr_rdy3", syn_rdy, 0);
    tick();
    chk("wr_a2", dend_addr, 8'h33);
    chk("wr_w2", dend_weight, 8'd3);
    chk("wr_rdy4", syn_rdy, 1);
    tick();
    chk("wr_end_vld", dend_vld, 0);

    // Zero-weight drop leaves a gap
    cfg(12'd20, 8'd1, 8'h20);
    cfg(12'd21, 8'd0, 8'h21);
    cfg(12'd22, 8'd3, 8'h22);
    cfg(12'd23, 8'd4, 8'h23);
    send_range(12'd20, 12'd23);
    tick();
    tick();
    chk("z_e2_vld", dend_vld, 1);
    chk("z_e2_addr", dend_addr, 8'h20);
    tick();
    chk("z_gap_vld", dend_vld, 0);
    tick();
    chk("z_e4_vld", dend_vld, 1);
    chk("z_e4_addr", dend_addr, 8'h22);
    tick();
    chk("z_e5_addr", dend_addr, 8'h23);
    chk("z_e5_wt", dend_weight, 8'd4);
    tick();
    chk("z_e6_vld", dend_vld, 0);

    // Backpressure: dend_rdy toggling
    for (int i = 0; i < 8; i++) cfg(12'(i), 8'(i + 1), 8'(8'h40 + i));
    dend_rdy = 1'b0;
    send_range(12'd0, 12'd7);
    k = 0;
    stall = 1'b0;
    pa = '0;
    pw = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (stall) begin
        chk("bp_hold_vld", dend_vld, 1);
        chk("bp_hold_addr", dend_addr, pa);
        chk("bp_hold_wt", dend_weight, pw);
      end
      dend_rdy = c[0];
      if (dend_vld && dend_rdy) begin
        chk("bp_order_addr", dend_addr, 32'h40 + k);
        chk("bp_order_wt", dend_weight, k + 1);
        k++;
      end
      stall = dend_vld && !dend_rdy;
      pa = dend_addr;
      pw = dend_weight;
    end
    chk("bp_count", k, 8);
    dend_rdy = 1'b1;
    tick();

    // Clear mid-range
    cfg(12'd100, 8'd7, 8'h70);
    cfg(12'd101, 8'd7, 8'h71);
    cfg(12'd102, 8'd7, 8'h72);
    send_range(12'd100, 12'd102);
    tick();
    tick();
    chk("cl_pre_vld", dend_vld, 1);
    clear_config = 1'b1;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (i == 1) begin
        chk("cl_vld_drop", dend_vld, 0);
        chk("cl_syn_rdy", syn_rdy, 0);
      end
      if (i == 4096) chk("cl_done_early", clear_done, 0);
    end
    tick();
    chk("cl_done", clear_done, 1);
    tick();
    chk("cl_done_hold", clear_done, 1);
    clear_config = 1'b0;
    tick();
    chk("cl_done_fall", clear_done, 0);
    chk("cl_idle_rdy", syn_rdy, 1);
    send_range(12'd10, 12'd11);
    nev = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dend_vld) nev++;
    end
    chk("cl_no_events", nev, 0);
    chk("cl_step_done", step_done, 1);

    // Reset mid-range
    cfg(12'd5, 8'd9, 8'h55);
    send_range(12'd5, 12'd6);
    tick();
    tick();
    chk("rs_pre_vld", dend_vld, 1);
    reset = 1'b0;
    #1;
    chk("rs_vld", dend_vld, 0);
    chk("rs_addr", dend_addr, 0);
    chk("rs_wt", dend_weight, 0);
    chk("rs_syn_rdy", syn_rdy, 0);
    chk("rs_step", step_done, 0);
    chk("rs_clear_done", clear_done, 0);
    tick();
    reset = 1'b1;
    nev = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dend_vld) nev++;
    end
    chk("rs_discard", nev, 0);
    chk("rs_post_rdy", syn_rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
